aq_spsram_init_wrap: RTL and testbench
======================================

// Module: aq_spsram_init_wrap
// PURPOSE
//  Parametrised single-port SRAM wrapper with request/response handshake and hardware clear-on-reset.
//  Replaces fixed-geometry SRAM wrappers in IFU/LSU arrays.
//  After reset it walks every entry, writing INIT_VALUE, then accepts one read or write per cycle.
//  It drives an internal active-low macro interface (CEN/GWEN/WEN) and returns read data with a valid strobe.
// PARAMETERS
//  ADDR_WIDTH  11            address bits; DEPTH = 2**ADDR_WIDTH
//  DATA_WIDTH  32            data bits per entry
//  WE_WIDTH    32            write-enable slices; DATA_WIDTH % WE_WIDTH == 0, slice = DATA_WIDTH/WE_WIDTH bits
//  INIT_VALUE  {DATA_WIDTH{1'b0}}  value written to every entry during clear
// PORTS
//  CLK        in   1           clock; all logic is rising-edge
//  RST        in   1           synchronous reset, active-high
//  req_vld    in   1           request valid
//  req_rdy    out  1           request ready; a request is accepted when req_vld & req_rdy
//  req_wr     in   1           1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH  entry address
//  req_wdata  in   DATA_WIDTH  write data
//  req_wmask  in   WE_WIDTH    active-high slice write mask; all-zero mask = no-op write
//  rsp_vld    out  1           read data valid, 1-cycle pulse per accepted read
//  rsp_data   out  DATA_WIDTH  read data; holds last read value while rsp_vld = 0
//  init_done  out  1           high once the clear sequence has completed
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values: req_rdy = 0, rsp_vld = 0, init_done = 0, rsp_data = 0, FSM state = INIT, clear counter = 0.
//  FSM INIT:
//   - Each cycle writes INIT_VALUE to entry cnt with all slices enabled, then cnt++.
//   - When cnt == DEPTH-1 is written, move to RUN on the next edge.
//   - The clear therefore takes exactly DEPTH cycles.
//  FSM RUN: req_rdy = 1 and init_done = 1. There is no exit except RST.
//  Requests in INIT are not accepted (req_rdy = 0). The requester must hold req_vld.
//  Accepted write:
//   - Macro CEN = 0, GWEN = 0, WEN = ~expanded(req_wmask).
//   - Only masked slices change; no response is generated.
//  Accepted read:
//   - CEN = 0, GWEN = 1.
//   - rsp_vld = 1 and rsp_data valid at cycle N+1 for acceptance at cycle N (base latency 1).
//  Back-to-back reads: one response per cycle, in order, no bubbles.
//  A read following a write to the same address (next cycle) returns the new data.
//  Idle: CEN = 1. The macro holds Q, and rsp_data holds.
//  Reset mid-INIT or mid-RUN:
//   - Counter returns to 0 and the clear restarts.
//   - A pending rsp_vld is squashed (0 on the cycle after RST).
//  Address/counter widths: the counter is ADDR_WIDTH+1 bits so the terminal compare cannot wrap.
// CONFIGURATION
//  AQ_SPSRAM_OUT_FLOP_EN defined:
//   - Adds an output register stage after the macro Q; read latency = 2.
//   - The rsp_vld pipeline is 2 deep; throughput stays 1 read per cycle.
//   - RST clears both rsp_vld stages.
//  Not defined: latency 1, and rsp_data is driven directly from the macro Q hold logic.
// STRUCTURE
//  Package aq_spsram_pkg:
//   - FSM state encoding (INIT = 1'b0, RUN = 1'b1).
//   - mask-expand function (WE_WIDTH -> DATA_WIDTH).
//   - latency constant AQ_SPSRAM_RD_LAT (1 or 2, per macro).
//  Sub-module aq_spsram_core:
//   - Behavioural DEPTH x DATA_WIDTH array with A/CEN/CLK/D/GWEN/WEN/Q, all active-low controls.
//   - Q is registered on a read and holds otherwise.
//   - Swappable for foundry macros.
// TESTING
//  1. Assert RST for 3 cycles, release, ADDR_WIDTH=4 -> req_rdy = 0 for 16 cycles, then init_done = 1; reading all 16 entries returns INIT_VALUE.
//  2. Write addr 5 = 0xDEADBEEF with full mask, then read addr 5 -> rsp_vld 1 cycle after the read (2 with OUT_FLOP), rsp_data = 0xDEADBEEF.
//  3. WE_WIDTH=4: write 0x11223344 to addr 2, then write 0xAABBCCDD mask 4'b0101 -> read returns 0x11BB33DD.
//  4. Back-to-back reads of addr 0..7 after distinct writes -> 8 consecutive rsp_vld pulses, data in order; rsp_data holds the addr-7 value after.
//  5. Pulse RST during INIT at cnt = 9 -> clear restarts from 0, still taking a full DEPTH cycles; pulse RST during a read -> no rsp_vld.
//  6. Hold req_vld with a write during INIT -> not accepted until RUN; the write takes effect exactly once, first RUN cycle.

Source files
------------

// File: rtl/aq_spsram_pkg.sv
// -----------------------------------------------------------------------------
// aq_spsram_pkg
// Shared definitions for the clear-on-reset single-port SRAM wrapper.
//   - aq_spsram_state_t : wrapper FSM encoding (INIT = 0, RUN = 1)
//   - AQ_SPSRAM_RD_LAT  : read latency in cycles from acceptance to rsp_vld
//   - expand_mask()     : widens a slice write mask to one bit per data bit
// Optional feature macro: AQ_SPSRAM_OUT_FLOP_EN (adds an output register,
// read latency becomes 2).
// -----------------------------------------------------------------------------
package aq_spsram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } aq_spsram_state_t;

`ifdef AQ_SPSRAM_OUT_FLOP_EN
    localparam int AQ_SPSRAM_RD_LAT = 2;
`else
    localparam int AQ_SPSRAM_RD_LAT = 1;
`endif

    // Widest data word the mask helper supports; callers size-cast in and out.
    localparam int AQ_SPSRAM_MAX_W = 1024;

    // Each mask bit s is replicated over data bits [s*slice +: slice],
    // slice = data_w / we_w. Built with shifts so no variable bit-select is
    // needed on the wide vectors.
    function automatic logic [AQ_SPSRAM_MAX_W-1:0] expand_mask(
        input logic [AQ_SPSRAM_MAX_W-1:0] mask,
        input int                         data_w,
        input int                         we_w
    );
        logic [AQ_SPSRAM_MAX_W-1:0] res;
        logic [AQ_SPSRAM_MAX_W-1:0] ones;
        logic [AQ_SPSRAM_MAX_W-1:0] msk;
        int                         slice;
        slice = data_w / we_w;
        res   = '0;
        msk   = mask;
        ones  = (AQ_SPSRAM_MAX_W'(1) << slice) - AQ_SPSRAM_MAX_W'(1);
        for (int s = 0; s < AQ_SPSRAM_MAX_W; s++) begin
            if (s < we_w && msk[0]) begin
                res = res | (ones << (s * slice));
            end
            msk = msk >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/aq_spsram_core.sv
// -----------------------------------------------------------------------------
// aq_spsram_core
// Behavioural DEPTH x DATA_WIDTH single-port SRAM with a foundry-style
// active-low control interface; drop-in replaceable by a hard macro.
// Ports:
//   CLK  in   clock, rising edge
//   A    in   ADDR_WIDTH  address
//   CEN  in   chip enable, active-low
//   GWEN in   global write enable, active-low (1 = read when CEN = 0)
//   WEN  in   DATA_WIDTH  per-bit write enable, active-low
//   D    in   DATA_WIDTH  write data
//   Q    out  DATA_WIDTH  read data, registered on a read, holds otherwise
// -----------------------------------------------------------------------------
module aq_spsram_core #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array and Q carry no reset, exactly like a real macro; the
    // wrapper's clear sequence is what gives the contents a known value.
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/aq_spsram_init_wrap.sv
// -----------------------------------------------------------------------------
// aq_spsram_init_wrap
// Parametrised single-port SRAM wrapper. After reset it writes INIT_VALUE to
// every entry (DEPTH cycles), then accepts one read or write per cycle.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous reset, active-high
//   req_vld    in   request valid
//   req_rdy    out  request ready (accept = req_vld & req_rdy)
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   ADDR_WIDTH entry address
//   req_wdata  in   DATA_WIDTH write data
//   req_wmask  in   WE_WIDTH   active-high slice write mask
//   rsp_vld    out  one-cycle pulse per accepted read
//   rsp_data   out  DATA_WIDTH read data, holds while rsp_vld = 0
//   init_done  out  high once the clear sequence has completed
// Optional feature macro: AQ_SPSRAM_OUT_FLOP_EN -> extra output register,
// read latency 2 instead of 1.
// -----------------------------------------------------------------------------
module aq_spsram_init_wrap
    import aq_spsram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WE_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    // One spare bit so the terminal compare cannot alias a wrapped count.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    aq_spsram_state_t      state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic                  rd_fire;
    logic                  rd_vld1;
    logic [DATA_WIDTH-1:0] wmask_exp;

    logic [ADDR_WIDTH-1:0] mac_a;
    logic                  mac_cen;
    logic                  mac_gwen;
    logic [DATA_WIDTH-1:0] mac_wen;
    logic [DATA_WIDTH-1:0] mac_d;
    logic [DATA_WIDTH-1:0] mac_q;

    assign wmask_exp = DATA_WIDTH'(expand_mask(AQ_SPSRAM_MAX_W'(req_wmask),
                                               DATA_WIDTH, WE_WIDTH));

    // NOTE: reset is sampled only on the clock edge (synchronous), so RST is
    // simply the highest-priority branch inside the clocked block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_rdy   = 1'b0;
        init_done = 1'b0;
        rd_fire   = 1'b0;
        mac_cen   = 1'b1;
        mac_gwen  = 1'b1;
        mac_wen   = '1;
        mac_a     = req_addr;
        mac_d     = req_wdata;
        case (state)
            ST_INIT: begin
                mac_cen  = 1'b0;
                mac_gwen = 1'b0;
                mac_wen  = '0;
                mac_a    = cnt[ADDR_WIDTH-1:0];
                mac_d    = INIT_VALUE;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                // A request seen alongside RST is refused rather than lost.
                req_rdy   = !RST;
                if (req_vld && !RST) begin
                    mac_cen = 1'b0;
                    if (req_wr) begin
                        mac_gwen = 1'b0;
                        mac_wen  = ~wmask_exp;
                    end else begin
                        rd_fire = 1'b1;
                    end
                end
            end
        endcase
    end

    aq_spsram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .CLK  (CLK),
        .A    (mac_a),
        .CEN  (mac_cen),
        .GWEN (mac_gwen),
        .WEN  (mac_wen),
        .D    (mac_d),
        .Q    (mac_q)
    );

    // rd_vld1 is high in the cycle mac_q carries fresh read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld1 <= 1'b0;
        end else begin
            rd_vld1 <= rd_fire;
        end
    end

`ifdef AQ_SPSRAM_OUT_FLOP_EN
    logic                  rd_vld2;
    logic [DATA_WIDTH-1:0] rsp_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld2 <= 1'b0;
            rsp_q   <= '0;
        end else begin
            rd_vld2 <= rd_vld1;
            if (rd_vld1) begin
                rsp_q <= mac_q;
            end
        end
    end

    assign rsp_vld  = rd_vld2;
    assign rsp_data = rsp_q;
`else
    // The macro Q already holds between reads; q_seen only masks the
    // unreset Q value until the first read after reset has returned.
    logic q_seen;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_seen <= 1'b0;
        end else if (rd_vld1) begin
            q_seen <= 1'b1;
        end
    end

    assign rsp_vld  = rd_vld1;
    assign rsp_data = (q_seen || rd_vld1) ? mac_q : '0;
`endif

endmodule

// File: tb/tb_aq_spsram_init_wrap.sv
// -----------------------------------------------------------------------------
// tb_aq_spsram_init_wrap
// Directed bench for aq_spsram_init_wrap (ADDR_WIDTH=4, WE_WIDTH=4). The
// driver pushes each read's expected data and arrival cycle into a queue;
// an independent monitor pops and compares on every rsp_vld.
// -----------------------------------------------------------------------------
module tb_aq_spsram_init_wrap;
    import aq_spsram_pkg::*;

    localparam int          AW     = 4;
    localparam int          DW     = 32;
    localparam int          WW     = 4;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] INIT_V = 32'h5A5A_C3C3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [WW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic [DW-1:0] rsp_data;
    logic          init_done;

    aq_spsram_init_wrap #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WE_WIDTH   (WW),
        .INIT_VALUE (INIT_V)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .init_done (init_done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          at_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding read.
    always @(negedge CLK) begin
        exp_t e;
        if (rsp_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_vld=1 data %0h expected no response (cycle %0d)",
                         rsp_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_cycle", 64'(cyc), 64'(e.at_cyc));
            end
        end
    end

    // Called just after a rising edge; holds the request until accepted.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [WW-1:0] mask, input logic [DW-1:0] exp_rd, output int waited);
        exp_t e;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        waited    = 0;
        @(negedge CLK);
        while (req_rdy !== 1'b1 && waited < 100) begin
            waited++;
            @(negedge CLK);
        end
        if (req_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_rdy=%b expected 1 within 100 cycles", req_rdy);
        end else if (!wr) begin
            e.data   = exp_rd;
            e.at_cyc = cyc + AQ_SPSRAM_RD_LAT;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_req(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [WW-1:0] mask);
        int w;
        issue(1'b1, addr, data, mask, '0, w);
    endtask

    task automatic rd_req(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        int w;
        issue(1'b0, addr, '0, '0, exp, w);
    endtask

    task automatic idle(input int n);
        req_vld = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called just after the edge on which RST was released.
    task automatic count_init(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (req_rdy !== 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check(name, 64'(n), 64'(DEPTH));
        check({name, "_done"}, 64'(init_done), 64'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_rst();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    logic [31:0] tbl [8] = '{32'h0000_0001, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
                             32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE};

    initial begin
        int w;

        // 1. Reset for 3 cycles, clear takes DEPTH cycles, all entries = INIT_V.
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        count_init("init_cycles");
        for (int a = 0; a < DEPTH; a++) rd_req(AW'(a), INIT_V);
        idle(3);

        // 2. Full-mask write then read-after-write on the next cycle.
        wr_req(4'd5, 32'hDEAD_BEEF, 4'hF);
        rd_req(4'd5, 32'hDEAD_BEEF);
        idle(3);

        // 3. Partial slice write: bytes 0 and 2 replaced.
        wr_req(4'd2, 32'h1122_3344, 4'hF);
        wr_req(4'd2, 32'hAABB_CCDD, 4'b0101);
        rd_req(4'd2, 32'h11BB_33DD);
        idle(3);

        // 4. Distinct writes, a zero-mask no-op, then 8 back-to-back reads.
        for (int a = 0; a < 8; a++) wr_req(AW'(a), tbl[a], 4'hF);
        wr_req(4'd7, 32'hFFFF_FFFF, 4'h0);
        for (int a = 0; a < 8; a++) rd_req(AW'(a), tbl[a]);
        idle(AQ_SPSRAM_RD_LAT + 2);
        @(negedge CLK);
        check("hold_rsp_vld", 64'(rsp_vld), 64'd0);
        check("hold_rsp_data", 64'(rsp_data), 64'(tbl[7]));
        @(posedge CLK);
        #1;

        // 5a. Reset at cnt = 9 restarts a full clear; old data is wiped.
        pulse_rst();
        repeat (9) @(posedge CLK);
        #1;
        pulse_rst();
        count_init("reinit_cycles");
        rd_req(4'd5, INIT_V);
        rd_req(4'd7, INIT_V);
        idle(3);

        // 5b. Read presented together with RST: no response follows.
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 4'd3;
        RST      = 1'b1;
        @(posedge CLK);
        #1;
        req_vld = 1'b0;
        RST     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("squash_rsp_vld", 64'(rsp_vld), 64'd0);
        end
        check("squash_rsp_data", 64'(rsp_data), 64'd0);
        @(posedge CLK);
        #1;

        // 6. Write held during INIT is accepted on the first RUN cycle only.
        pulse_rst();
        issue(1'b1, 4'd3, 32'hCAFE_F00D, 4'hF, '0, w);
        check("held_wr_wait", 64'(w), 64'(DEPTH));
        rd_req(4'd3, 32'hCAFE_F00D);
        rd_req(4'd4, INIT_V);
        idle(5);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
